// File: rtl/sparse_cnn_frame_ctrl.sv
// Frame controller for the SparseCNN core: compresses a dense KxK kernel into packed
// nonzero value/row/col buses, streams one IMG x IMG feature frame, then awaits the core result.
module sparse_cnn_frame_ctrl #(
  parameter int WORD_LENGTH = 8,
  parameter int KERNEL_SIZE = 5,
  parameter int IMAGE_SIZE  = 28,
  parameter int NUM_SLOTS   = 28,
  parameter int TIMEOUT     = 4096
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             w_in_valid,
  input  logic [WORD_LENGTH-1:0]           w_in,
  output logic                             w_in_ready,
  input  logic                             f_in_valid,
  input  logic [WORD_LENGTH-1:0]           f_in,
  output logic                             f_in_ready,
  output logic                             core_feature_valid,
  output logic [WORD_LENGTH-1:0]           core_feature,
  output logic [NUM_SLOTS*WORD_LENGTH-1:0] pe_input_weight_value,
  output logic [NUM_SLOTS*WORD_LENGTH-1:0] pe_input_weight_rows,
  output logic [NUM_SLOTS*WORD_LENGTH-1:0] pe_input_weight_cols,
  output logic [2*WORD_LENGTH-1:0]         weight_valid_num,
  input  logic                             core_out_valid,
  output logic                             busy,
  output logic                             done,
  output logic                             timeout_err,
  output logic [2:0]                       state_dbg
);

  localparam int W      = WORD_LENGTH;
  localparam int KK     = KERNEL_SIZE * KERNEL_SIZE;
  localparam int NPIX   = IMAGE_SIZE * IMAGE_SIZE;
  localparam int CNT_W  = 2 * WORD_LENGTH;
  localparam int IDX_W  = $clog2(KK + 1);
  localparam int RC_W   = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int PIX_W  = $clog2(NPIX + 1);
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_W   = 3'd1,
    S_STREAM   = 3'd2,
    S_WAIT_OUT = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]  w_idx;
  logic [RC_W-1:0]   row, col;
  logic [PIX_W-1:0]  pix_cnt;
  logic [WAIT_W-1:0] wait_cnt;

  // valid/ready: a word transfers on every rising edge where both are high;
  // the producer may hold valid low for any number of cycles.
  logic start_acc, w_acc, f_acc, last_w, last_pix, wait_hit, slot_wr;

  assign start_acc = (state == S_IDLE) && start;
  assign w_acc     = (state == S_LOAD_W) && w_in_valid;
  assign f_acc     = (state == S_STREAM) && f_in_valid;
  assign last_w    = w_acc && (w_idx == IDX_W'(KK - 1));
  assign last_pix  = f_acc && (pix_cnt == PIX_W'(NPIX - 1));
  assign wait_hit  = (wait_cnt == WAIT_W'(TIMEOUT - 1));
  assign slot_wr   = w_acc && (w_in != '0) && (weight_valid_num < CNT_W'(NUM_SLOTS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (start) state_nxt = S_LOAD_W;
      S_LOAD_W:   if (last_w) state_nxt = S_STREAM;
      S_STREAM:   if (last_pix) state_nxt = S_WAIT_OUT;
      // a result arriving on the timeout cycle still counts as success
      S_WAIT_OUT: begin
        if (core_out_valid)  state_nxt = S_DONE;
        else if (wait_hit)   state_nxt = S_IDLE;
      end
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready = (state == S_LOAD_W);
    f_in_ready = (state == S_STREAM);
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
    state_dbg  = state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_idx <= '0;
      row   <= '0;
      col   <= '0;
    end else if (start_acc) begin
      w_idx <= '0;
      row   <= '0;
      col   <= '0;
    end else if (w_acc) begin
      w_idx <= w_idx + IDX_W'(1);
      if (col == RC_W'(KERNEL_SIZE - 1)) begin
        col <= '0;
        row <= row + RC_W'(1);
      end else begin
        col <= col + RC_W'(1);
      end
    end
  end

  // Nonzero weights are packed densely from slot 0; unused slots stay zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pe_input_weight_value <= '0;
      pe_input_weight_rows  <= '0;
      pe_input_weight_cols  <= '0;
      weight_valid_num      <= '0;
    end else if (start_acc) begin
      pe_input_weight_value <= '0;
      pe_input_weight_rows  <= '0;
      pe_input_weight_cols  <= '0;
      weight_valid_num      <= '0;
    end else if (slot_wr) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (weight_valid_num == CNT_W'(s)) begin
          pe_input_weight_value[s*W +: W] <= w_in;
          pe_input_weight_rows[s*W +: W]  <= W'(row);
          pe_input_weight_cols[s*W +: W]  <= W'(col);
        end
      end
      weight_valid_num <= weight_valid_num + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_cnt            <= '0;
      core_feature       <= '0;
      core_feature_valid <= 1'b0;
    end else begin
      core_feature_valid <= f_acc;
      if (f_acc) core_feature <= f_in;
      if (start_acc)  pix_cnt <= '0;
      else if (f_acc) pix_cnt <= pix_cnt + PIX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == S_WAIT_OUT) wait_cnt <= wait_cnt + WAIT_W'(1);
      else                     wait_cnt <= '0;
      if (start_acc)
        timeout_err <= 1'b0;
      else if ((state == S_WAIT_OUT) && !core_out_valid && wait_hit)
        timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sparse_cnn_frame_ctrl.sv
// Scoreboard bench for sparse_cnn_frame_ctrl: directed kernels and frames, with a
// monitor that checks features, done pulses and packed weight buses against queued expectations.
`timescale 1ns/1ps
module tb_sparse_cnn_frame_ctrl;
  localparam int W    = 8;
  localparam int K    = 5;
  localparam int IMG  = 28;
  localparam int NS   = 28;
  localparam int TO   = 16;
  localparam int KK   = K * K;
  localparam int NPIX = IMG * IMG;
  localparam int BW   = NS * W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic            start = 1'b0;
  logic            w_in_valid = 1'b0;
  logic [W-1:0]    w_in = '0;
  logic            w_in_ready;
  logic            f_in_valid = 1'b0;
  logic [W-1:0]    f_in = '0;
  logic            f_in_ready;
  logic            core_feature_valid;
  logic [W-1:0]    core_feature;
  logic [BW-1:0]   pe_input_weight_value, pe_input_weight_rows, pe_input_weight_cols;
  logic [2*W-1:0]  weight_valid_num;
  logic            core_out_valid = 1'b0;
  logic            busy, done, timeout_err;
  logic [2:0]      state_dbg;

  sparse_cnn_frame_ctrl #(
    .WORD_LENGTH(W), .KERNEL_SIZE(K), .IMAGE_SIZE(IMG), .NUM_SLOTS(NS), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .w_in_valid(w_in_valid), .w_in(w_in), .w_in_ready(w_in_ready),
    .f_in_valid(f_in_valid), .f_in(f_in), .f_in_ready(f_in_ready),
    .core_feature_valid(core_feature_valid), .core_feature(core_feature),
    .pe_input_weight_value(pe_input_weight_value),
    .pe_input_weight_rows(pe_input_weight_rows),
    .pe_input_weight_cols(pe_input_weight_cols),
    .weight_valid_num(weight_valid_num), .core_out_valid(core_out_valid),
    .busy(busy), .done(done), .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [W-1:0]   exp_q[$];
  int             exp_cyc_q[$];
  logic [BW-1:0]  exp_val_q[$], exp_row_q[$], exp_col_q[$];
  logic [2*W-1:0] exp_cnt_q[$];
  bit             exp_done_q[$];
  logic [BW-1:0]  m_val, m_row, m_col;
  logic [2*W-1:0] m_cnt;
  int feat_pulses = 0, wait_cycles = 0, lw_cyc = 0, st_cyc = 0;

  logic [W-1:0] kern[KK];
  logic [W-1:0] dense_k[KK] = '{8'h01, 8'hff, 8'hfd, 8'hf8, 8'hf9, 8'h04, 8'h07, 8'h02, 8'hfe,
                                8'h05, 8'h0a, 8'hf0, 8'h03, 8'h06, 8'hfb, 8'h09, 8'h0c, 8'hf2,
                                8'h11, 8'h08, 8'hfa, 8'h0e, 8'h13, 8'hf7, 8'h0b};

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- monitor ----------------
  initial begin
    logic prev_wr, prev_fr;
    prev_wr = 1'b0;
    prev_fr = 1'b0;
    forever begin
      @(negedge clk);
      if (core_feature_valid) begin
        feat_pulses++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL feature_unexpected: got %0h, expected no pulse", core_feature);
        end else begin
          check("feature_data", core_feature, exp_q.pop_front());
          check("feature_latency", cyc - exp_cyc_q.pop_front(), 1);
        end
      end
      if (done) begin
        if (exp_done_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL done_unexpected: got 1, expected 0");
        end else begin
          void'(exp_done_q.pop_front());
          check("done_busy", busy, 1);
        end
      end
      if (state_dbg == 3'd3) wait_cycles++;
      if (w_in_ready && !prev_wr) lw_cyc = cyc;
      if (f_in_ready && !prev_fr) begin
        st_cyc = cyc;
        if (exp_cnt_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL stream_entry_unexpected: got stream, expected none");
        end else begin
          check("bus_count", weight_valid_num, exp_cnt_q.pop_front());
          check("bus_value", pe_input_weight_value, exp_val_q.pop_front());
          check("bus_rows", pe_input_weight_rows, exp_row_q.pop_front());
          check("bus_cols", pe_input_weight_cols, exp_col_q.pop_front());
        end
      end
      prev_wr = w_in_ready;
      prev_fr = f_in_ready;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_bus_model();
    int n;
    n = 0;
    m_val = '0;
    m_row = '0;
    m_col = '0;
    for (int i = 0; i < KK; i++) begin
      if (kern[i] != '0 && n < NS) begin
        m_val[n*W +: W] = kern[i];
        m_row[n*W +: W] = W'(i / K);
        m_col[n*W +: W] = W'(i % K);
        n++;
      end
    end
    m_cnt = (2*W)'(n);
    exp_val_q.push_back(m_val);
    exp_row_q.push_back(m_row);
    exp_col_q.push_back(m_col);
    exp_cnt_q.push_back(m_cnt);
  endtask

  task automatic start_frame();
    feat_pulses = 0;
    wait_cycles = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic load_kernel(input int stall_mod);
    int i, att;
    logic acc;
    i = 0;
    att = 0;
    while (i < KK) begin
      w_in_valid = !(stall_mod > 0 && (att % stall_mod) == stall_mod - 1);
      w_in = kern[i];
      @(negedge clk);
      acc = w_in_valid && w_in_ready;
      @(posedge clk); #1;
      att++;
      if (acc) i++;
      if (att > 4 * KK) begin
        n_tests++;
        n_fail++;
        $display("FAIL load_timeout: got %0d accepts, expected %0d", i, KK);
        break;
      end
    end
    w_in_valid = 1'b0;
    w_in = '0;
  endtask

  // Also pulses start and core_out_valid mid-frame; both must be ignored.
  task automatic stream_frame(input int stall_mod, input int stop_at, input int seed);
    int p, att;
    logic acc;
    logic [W-1:0] pix;
    p = 0;
    att = 0;
    while (p < stop_at) begin
      pix = W'(p * 7 + seed);
      f_in_valid = !(stall_mod > 0 && (att % stall_mod) == stall_mod - 1);
      f_in = pix;
      core_out_valid = (p == 100);
      start = (p == 50);
      @(negedge clk);
      acc = f_in_valid && f_in_ready;
      if (acc) begin
        exp_q.push_back(pix);
        exp_cyc_q.push_back(cyc);
      end
      @(posedge clk); #1;
      att++;
      if (acc) p++;
      if (att > 3 * NPIX) begin
        n_tests++;
        n_fail++;
        $display("FAIL stream_timeout: got %0d accepts, expected %0d", p, stop_at);
        break;
      end
    end
    core_out_valid = 1'b0;
    start = 1'b0;
    if (stop_at == NPIX) begin
      f_in = 8'hee;
      f_in_valid = 1'b1;
      @(negedge clk);
      check("f_in_ready_after_last", f_in_ready, 0);
      @(posedge clk); #1;
      f_in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (busy && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    check("return_to_idle", busy, 0);
  endtask

  task automatic finish_frame(input int out_delay);
    if (out_delay >= 0) begin
      repeat (out_delay) begin
        @(posedge clk); #1;
      end
      core_out_valid = 1'b1;
      exp_done_q.push_back(1'b1);
      @(posedge clk); #1;
      core_out_valid = 1'b0;
    end
    wait_idle(40);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {w_in_ready, f_in_ready, core_feature_valid, core_feature,
                           weight_valid_num, busy, done, timeout_err, state_dbg}, 0);
    check({tag, "_value"}, pe_input_weight_value, 0);
    check({tag, "_rows"}, pe_input_weight_rows, 0);
    check({tag, "_cols"}, pe_input_weight_cols, 0);
  endtask

  task automatic set_dense();
    for (int i = 0; i < KK; i++) kern[i] = dense_k[i];
  endtask

  task automatic set_sparse();
    for (int i = 0; i < KK; i++) kern[i] = '0;
    kern[0]  = 8'h03;
    kern[7]  = 8'hfc;
    kern[24] = 8'h09;
  endtask

  task automatic set_zero();
    for (int i = 0; i < KK; i++) kern[i] = '0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // dense kernel, no stalls
    set_dense();
    push_bus_model();
    start_frame();
    load_kernel(0);
    check("dense_count", weight_valid_num, 25);
    check("dense_slot0", {pe_input_weight_value[7:0], pe_input_weight_rows[7:0],
                          pe_input_weight_cols[7:0]}, 24'h01_00_00);
    check("dense_slot24_rc", {pe_input_weight_rows[24*W +: W], pe_input_weight_cols[24*W +: W]},
          16'h04_04);
    check("dense_slots25_27", {pe_input_weight_value[BW-1:25*W], pe_input_weight_rows[BW-1:25*W],
                               pe_input_weight_cols[BW-1:25*W]}, 0);
    stream_frame(0, NPIX, 3);
    check("dense_stream_entry_cycles", st_cyc - lw_cyc, 25);
    finish_frame(5);
    check("dense_pulses", feat_pulses, NPIX);
    check("dense_value_hold", pe_input_weight_value, m_val);
    check("dense_rows_hold", pe_input_weight_rows, m_row);
    check("dense_timeout_err", timeout_err, 0);

    // sparse kernel, stalled weights and features
    set_sparse();
    push_bus_model();
    start_frame();
    load_kernel(2);
    check("sparse_count", weight_valid_num, 3);
    check("sparse_slot0", {pe_input_weight_value[7:0], pe_input_weight_rows[7:0],
                           pe_input_weight_cols[7:0]}, 24'h03_00_00);
    check("sparse_slot1", {pe_input_weight_value[W +: W], pe_input_weight_rows[W +: W],
                           pe_input_weight_cols[W +: W]}, 24'hfc_01_02);
    check("sparse_slot2", {pe_input_weight_value[2*W +: W], pe_input_weight_rows[2*W +: W],
                           pe_input_weight_cols[2*W +: W]}, 24'h09_04_04);
    check("sparse_rest_value", pe_input_weight_value[BW-1:3*W], 0);
    check("sparse_rest_rc", {pe_input_weight_rows[BW-1:3*W], pe_input_weight_cols[BW-1:3*W]}, 0);
    stream_frame(3, NPIX, 11);
    finish_frame(2);
    check("sparse_pulses", feat_pulses, NPIX);

    // all-zero kernel
    set_zero();
    push_bus_model();
    start_frame();
    load_kernel(0);
    check("zero_count", weight_valid_num, 0);
    check("zero_value", pe_input_weight_value, 0);
    check("zero_rc", {pe_input_weight_rows, pe_input_weight_cols}, 0);
    stream_frame(0, NPIX, 29);
    finish_frame(0);
    check("zero_pulses", feat_pulses, NPIX);

    // core never answers: timeout after TO WAIT_OUT cycles, no done
    set_dense();
    push_bus_model();
    start_frame();
    load_kernel(0);
    stream_frame(0, NPIX, 5);
    finish_frame(-1);
    check("timeout_wait_cycles", wait_cycles, TO);
    check("timeout_err_set", timeout_err, 1);
    check("timeout_state", state_dbg, 0);

    // reset mid-stream at 300 pixels
    set_sparse();
    push_bus_model();
    start_frame();
    check("timeout_err_cleared", timeout_err, 0);
    load_kernel(0);
    stream_frame(0, 300, 17);
    f_in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // full frame after the aborted one
    set_dense();
    push_bus_model();
    start_frame();
    load_kernel(0);
    check("recover_count", weight_valid_num, 25);
    stream_frame(3, NPIX, 41);
    finish_frame(0);
    check("recover_pulses", feat_pulses, NPIX);
    check("recover_cols_hold", pe_input_weight_cols, m_col);

    repeat (3) @(posedge clk);
    #1;
    check("feature_queue_empty", exp_q.size(), 0);
    check("done_queue_empty", exp_done_q.size(), 0);
    check("bus_queue_empty", exp_cnt_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: got no completion, expected finish before 1ms");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
